// File: rtl/answer_judge.sv
// Factor-answer judge: arms on START, checks player factor pairs, reports local/opponent/timeout result.
// Optional feature macro ANSWER_JUDGE_TIMEOUT_EN adds an answer-window timeout (result 11).
module answer_judge #(
  parameter int unsigned TW          = 8,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [TW-1:0]   TARGET,
  input  logic [TW/2-1:0] FACT_A,
  input  logic [TW/2-1:0] FACT_B,
  input  logic            SUBMIT,
  input  logic            OPP_DONE,
  output logic [1:0]      JUDG,
  output logic [1:0]      WRONG,
  output logic            QUE,
  output logic            BUSY
);

  localparam int unsigned HW = TW / 2;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_LOCAL   = 2'b01;
  localparam logic [1:0] RES_OPP     = 2'b10;
  localparam logic [1:0] WRONG_MAX   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_CHECK  = 3'd2,
    S_REPORT = 3'd3,
    S_NEXT   = 3'd4
  } state_t;

  if (TIMEOUT_CYC == 0) begin : g_timeout_cfg_err
    $error("answer_judge: TIMEOUT_CYC must be nonzero");
  end

  state_t          state_q, state_d;
  logic [TW-1:0]   target_q, target_d;
  logic [HW-1:0]   fa_q, fa_d;
  logic [HW-1:0]   fb_q, fb_d;
  logic [1:0]      wrong_q, wrong_d;
  logic [1:0]      judg_q, judg_d;
  logic            que_q, que_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   product_c;
  logic            correct_c;
  logic            timeout_c;

  // Full-width product so no factor pair can alias onto the target by truncation.
  assign product_c = TW'(fa_q) * TW'(fb_q);
  assign correct_c = (product_c == target_q) && (fa_q >= HW'(2)) && (fb_q >= HW'(2));

`ifdef ANSWER_JUDGE_TIMEOUT_EN
  localparam int unsigned    TMW       = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TMW-1:0] TIMER_LIM = TMW'(TIMEOUT_CYC);
  localparam logic [1:0]     RES_TIMEOUT = 2'b11;

  logic [TMW-1:0] timer_q, timer_d;

  // Saturating count of ARMED/CHECK cycles since the accepted START.
  assign timeout_c = (timer_q >= TIMER_LIM);

  always_comb begin
    timer_d = timer_q;
    if ((state_q == S_IDLE) && START) begin
      timer_d = '0;
    end else if (((state_q == S_ARMED) || (state_q == S_CHECK)) && !timeout_c) begin
      timer_d = timer_q + TMW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    wrong_d  = wrong_q;
    judg_d   = RES_NONE;
    que_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_ARMED;
          target_d = TARGET;
          wrong_d  = 2'b00;
        end
      end
      S_ARMED: begin
        if (timeout_c) begin
`ifdef ANSWER_JUDGE_TIMEOUT_EN
          state_d = S_REPORT;
          judg_d  = RES_TIMEOUT;
`endif
        end else if (OPP_DONE) begin
          state_d = S_REPORT;
          judg_d  = RES_OPP;
        end else if (SUBMIT && (wrong_q != WRONG_MAX)) begin
          state_d = S_CHECK;
          fa_d    = FACT_A;
          fb_d    = FACT_B;
        end
      end
      S_CHECK: begin
        if (correct_c) begin
          state_d = S_REPORT;
          judg_d  = RES_LOCAL;
        end else begin
          if (wrong_q != WRONG_MAX) wrong_d = wrong_q + 2'd1;
          if (OPP_DONE) begin
            state_d = S_REPORT;
            judg_d  = RES_OPP;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      S_REPORT: begin
        state_d = S_NEXT;
        que_d   = 1'b1;
      end
      S_NEXT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      wrong_q  <= '0;
      judg_q   <= RES_NONE;
      que_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      wrong_q  <= wrong_d;
      judg_q   <= judg_d;
      que_q    <= que_d;
      busy_q   <= busy_d;
    end
  end

  assign JUDG  = judg_q;
  assign WRONG = wrong_q;
  assign QUE   = que_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_answer_judge.sv
// Self-checking bench for answer_judge: directed scenarios plus randomized traffic vs a timestamp-based model.
module tb_answer_judge;

  localparam int unsigned TW = 8;
  localparam int unsigned HW = TW / 2;
  localparam int unsigned TO = 10;
`ifdef ANSWER_JUDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [TW-1:0] TARGET = '0;
  logic [HW-1:0] FACT_A = '0;
  logic [HW-1:0] FACT_B = '0;
  logic          SUBMIT = 1'b0;
  logic          OPP_DONE = 1'b0;
  logic [1:0]    JUDG;
  logic [1:0]    WRONG;
  logic          QUE;
  logic          BUSY;

  answer_judge #(.TW(TW), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .START(START), .TARGET(TARGET),
    .FACT_A(FACT_A), .FACT_B(FACT_B), .SUBMIT(SUBMIT), .OPP_DONE(OPP_DONE),
    .JUDG(JUDG), .WRONG(WRONG), .QUE(QUE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: a question is "open" until a result is scheduled; results are timestamps.
  bit         m_open    = 1'b0;
  int         m_wrong   = 0;
  int         m_target  = 0;
  int         m_a       = 0;
  int         m_b       = 0;
  int         m_sub_cyc = -10;
  int         m_judg_at = -1;
  int         m_que_at  = -1;
  int         m_idle_at = 0;
  int         m_res     = 0;
  int         m_tstart  = 0;
  logic [5:0] exp_vec   = '0;

  function automatic logic [5:0] outs();
    return {JUDG, WRONG, QUE, BUSY};
  endfunction

  task automatic finish_q(input int r);
    m_open    = 1'b0;
    m_res     = r;
    m_judg_at = cyc + 1;
    m_que_at  = cyc + 2;
    m_idle_at = cyc + 3;
  endtask

  task automatic model_cycle(input bit st, input int t, input int a, input int b,
                             input bit sub, input bit opp, input bit rst);
    if (rst) begin
      m_open = 1'b0; m_wrong = 0; m_sub_cyc = -10;
      m_judg_at = -1; m_que_at = -1; m_idle_at = 0;
    end else if (!m_open) begin
      if (cyc >= m_idle_at && st) begin
        m_open = 1'b1; m_target = t; m_wrong = 0; m_tstart = cyc;
      end
    end else if (cyc == m_sub_cyc + 1) begin
      if (m_a * m_b == m_target && m_a >= 2 && m_b >= 2) finish_q(1);
      else begin
        if (m_wrong < 3) m_wrong++;
        if (opp) finish_q(2);
      end
    end else if (TO_EN && (cyc - m_tstart - 1 >= int'(TO))) begin
      finish_q(3);
    end else if (opp) begin
      finish_q(2);
    end else if (sub && m_wrong < 3) begin
      m_sub_cyc = cyc; m_a = a; m_b = b;
    end
    exp_vec = {((cyc + 1 == m_judg_at) ? 2'(m_res) : 2'b00), 2'(m_wrong),
               (cyc + 1 == m_que_at), (m_open || (cyc + 1 < m_idle_at))};
  endtask

  // Drive one cycle of inputs, advance the model, then settle just after the edge.
  task automatic tick(input bit st, input int t, input int a, input int b,
                      input bit sub, input bit opp, input bit rst);
    RST = rst; START = st; TARGET = TW'(t); FACT_A = HW'(a); FACT_B = HW'(b);
    SUBMIT = sub; OPP_DONE = opp;
    model_cycle(st, t, a, b, sub, opp, rst);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle_tick();
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (outs() !== 6'b0) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", outs(), 6'b0);
    end
    // Reset while a wrong answer is being checked.
    tick(1'b1, 15, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 0, 1, 15, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (outs() !== 6'b0) begin
      n_fail++; $display("FAIL reset_in_check: got %b want %b", outs(), 6'b0);
    end
    for (int i = 0; i < 4; i++) begin
      idle_tick();
      n_tests++;
      if (JUDG !== 2'b00 || BUSY !== 1'b0) begin
        n_fail++; $display("FAIL reset_quiet: judg %b busy %b want 00 0", JUDG, BUSY);
      end
    end
  endtask

  task automatic test_correct();
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 15, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 0, 3, 5, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (JUDG !== 2'b00 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL correct_check_cycle: judg %b busy %b want 00 1", JUDG, BUSY);
    end
    idle_tick();
    n_tests++;
    if (JUDG !== 2'b01 || QUE !== 1'b0) begin
      n_fail++; $display("FAIL correct_judg: judg %b que %b want 01 0", JUDG, QUE);
    end
    idle_tick();
    n_tests++;
    if (QUE !== 1'b1 || JUDG !== 2'b00 || WRONG !== 2'b00) begin
      n_fail++; $display("FAIL correct_que: que %b judg %b wrong %b want 1 00 00", QUE, JUDG, WRONG);
    end
    idle_tick();
    n_tests++;
    if (BUSY !== 1'b0 || QUE !== 1'b0) begin
      n_fail++; $display("FAIL correct_idle: busy %b que %b want 0 0", BUSY, QUE);
    end
  endtask

  task automatic test_wrong_then_right();
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 15, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 0, 1, 15, 1'b1, 1'b0, 1'b0);
    idle_tick();
    n_tests++;
    if (WRONG !== 2'b01 || JUDG !== 2'b00) begin
      n_fail++; $display("FAIL wrong_first: wrong %b judg %b want 01 00", WRONG, JUDG);
    end
    tick(1'b0, 0, 2, 7, 1'b1, 1'b0, 1'b0);
    idle_tick();
    n_tests++;
    if (WRONG !== 2'b10) begin
      n_fail++; $display("FAIL wrong_second: wrong %b want 10", WRONG);
    end
    tick(1'b0, 0, 3, 5, 1'b1, 1'b0, 1'b0);
    idle_tick();
    n_tests++;
    if (JUDG !== 2'b01 || WRONG !== 2'b10) begin
      n_fail++; $display("FAIL wrong_then_right: judg %b wrong %b want 01 10", JUDG, WRONG);
    end
    idle_tick();
    idle_tick();
  endtask

  task automatic test_lockout();
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 21, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 0, 1, 1, 1'b1, 1'b0, 1'b0); idle_tick();
    tick(1'b0, 0, 2, 2, 1'b1, 1'b0, 1'b0); idle_tick();
    tick(1'b0, 0, 4, 5, 1'b1, 1'b0, 1'b0); idle_tick();
    n_tests++;
    if (WRONG !== 2'b11) begin
      n_fail++; $display("FAIL lockout_sat: wrong %b want 11", WRONG);
    end
    // A correct pair while locked out must never be judged.
    tick(1'b0, 0, 3, 7, 1'b1, 1'b0, 1'b0);
    idle_tick();
    n_tests++;
    if (JUDG !== 2'b00 || WRONG !== 2'b11 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL lockout_ignored: judg %b wrong %b busy %b want 00 11 1", JUDG, WRONG, BUSY);
    end
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (JUDG !== 2'b10) begin
      n_fail++; $display("FAIL lockout_opp: judg %b want 10", JUDG);
    end
    idle_tick();
    n_tests++;
    if (QUE !== 1'b1 || WRONG !== 2'b11) begin
      n_fail++; $display("FAIL lockout_que: que %b wrong %b want 1 11", QUE, WRONG);
    end
    idle_tick();
  endtask

  task automatic test_collision();
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 15, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 0, 3, 5, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (JUDG !== 2'b10 || WRONG !== 2'b00) begin
      n_fail++; $display("FAIL collision: judg %b wrong %b want 10 00", JUDG, WRONG);
    end
    idle_tick();
    idle_tick();
  endtask

  task automatic test_timeout();
    bit seen11 = 1'b0;
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 15, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(TO) + 20; i++) begin
      idle_tick();
      if (JUDG === 2'b11) seen11 = 1'b1;
      n_tests++;
      if (outs() !== exp_vec) begin
        n_fail++; $display("FAIL timeout_trace cyc %0d: got %b want %b", cyc, outs(), exp_vec);
      end
    end
    n_tests++;
    if (seen11 !== TO_EN) begin
      n_fail++; $display("FAIL timeout_result: saw11 %b want %b", seen11, TO_EN);
    end
    n_tests++;
    if (BUSY !== !TO_EN) begin
      n_fail++; $display("FAIL timeout_busy: busy %b want %b", BUSY, !TO_EN);
    end
  endtask

  task automatic test_random();
    int ra = 3, rb = 5;
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      bit st, sub, opp, rst;
      int t, a, b;
      rst = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 3) == 0);
      sub = ($urandom_range(0, 2) == 0);
      opp = ($urandom_range(0, 11) == 0);
      if (st) begin
        ra = $urandom_range(0, 15); rb = $urandom_range(0, 15);
        t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : ra * rb;
      end else begin
        t = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 2) == 0) begin
        a = ra; b = rb;
      end else begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      end
      tick(st, t, a, b, sub, opp, rst);
      n_tests++;
      if (outs() !== exp_vec) begin
        n_fail++; $display("FAIL random cyc %0d: got %b want %b", cyc, outs(), exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong_then_right();
    test_lockout();
    test_collision();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
